// File: rtl/d_cache_ctrl_pkg.sv
// Shared geometry, FSM encoding and address field helpers for the
// direct-mapped data cache controller.
package d_cache_ctrl_pkg;

  localparam int ADDR_W_P   = 16;
  localparam int DATA_W_P   = 8;
  localparam int INDEX_W_P  = 4;
  localparam int OFFSET_W_P = 2;

  localparam int TAG_W = ADDR_W_P - INDEX_W_P - OFFSET_W_P;
  localparam int LINES = 1 << INDEX_W_P;
  localparam int WORDS = 1 << OFFSET_W_P;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WB   = 2'b01,
    ST_FILL = 2'b10,
    ST_DONE = 2'b11
  } state_t;

  function automatic logic [TAG_W-1:0] get_tag(input logic [ADDR_W_P-1:0] addr);
    return addr[ADDR_W_P-1 -: TAG_W];
  endfunction

  function automatic logic [INDEX_W_P-1:0] get_idx(input logic [ADDR_W_P-1:0] addr);
    return addr[OFFSET_W_P +: INDEX_W_P];
  endfunction

  function automatic logic [OFFSET_W_P-1:0] get_off(input logic [ADDR_W_P-1:0] addr);
    return addr[OFFSET_W_P-1:0];
  endfunction

endpackage

// File: rtl/d_cache_tag_store.sv
// Per-line valid/dirty/tag storage with a single lookup index shared by
// hit compare, victim readout, install and dirty marking.
module d_cache_tag_store
  import d_cache_ctrl_pkg::*;
#(
  parameter int INDEX_W  = INDEX_W_P,
  parameter int TAG_BITS = TAG_W
) (
  input  logic                clk,
  input  logic                RST,
  input  logic [INDEX_W-1:0]  idx,
  input  logic [TAG_BITS-1:0] lookup_tag,
  output logic                hit,
  output logic                line_valid,
  output logic                line_dirty,
  output logic [TAG_BITS-1:0] line_tag,
  input  logic                install,
  input  logic [TAG_BITS-1:0] install_tag,
  input  logic                set_dirty
);

  localparam int NL = 1 << INDEX_W;

  logic [NL-1:0]       valid_reg;
  logic [NL-1:0]       dirty_reg;
  logic [TAG_BITS-1:0] tag_mem [NL];

  // Only valid/dirty need reset; tags are meaningless while invalid.
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      valid_reg <= '0;
      dirty_reg <= '0;
    end else if (install) begin
      valid_reg[idx] <= 1'b1;
      dirty_reg[idx] <= 1'b0;
    end else if (set_dirty) begin
      dirty_reg[idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (install) begin
      tag_mem[idx] <= install_tag;
    end
  end

  assign line_valid = valid_reg[idx];
  assign line_dirty = dirty_reg[idx];
  assign line_tag   = tag_mem[idx];
  assign hit        = line_valid && (line_tag == lookup_tag);

endmodule

// File: rtl/d_cache_ctrl.sv
// Direct-mapped write-back/write-allocate data cache controller: zero-latency
// hits, and a miss FSM that writes back a dirty victim then fills the line.
module d_cache_ctrl
  import d_cache_ctrl_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_P,
  parameter int DATA_W   = DATA_W_P,
  parameter int INDEX_W  = INDEX_W_P,
  parameter int OFFSET_W = OFFSET_W_P
) (
  input  logic              clk,
  input  logic              RST,
  input  logic              cpu_rd,
  input  logic              cpu_wr,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              d_cache_miss,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack
);

  localparam int TW = ADDR_W - INDEX_W - OFFSET_W;
  localparam int NL = 1 << INDEX_W;
  localparam int NW = 1 << OFFSET_W;

  state_t              state_reg, state_next;
  logic [OFFSET_W-1:0] cnt_reg, cnt_next;
  logic [TW-1:0]       req_tag_reg, req_tag_next;
  logic [INDEX_W-1:0]  req_idx_reg, req_idx_next;

  logic [DATA_W-1:0]   data_mem [NL][NW];

  logic [TW-1:0]       cpu_tag;
  logic [INDEX_W-1:0]  cpu_idx;
  logic [OFFSET_W-1:0] cpu_off;
  logic [INDEX_W-1:0]  lookup_idx;
  logic                cpu_req;
  logic                tag_hit;
  logic                line_valid;
  logic                line_dirty;
  logic [TW-1:0]       line_tag;
  logic                install;
  logic                fill_wr;
  logic                hit_wr;
  logic                last_beat;

  assign cpu_tag   = get_tag(cpu_addr);
  assign cpu_idx   = get_idx(cpu_addr);
  assign cpu_off   = get_off(cpu_addr);
  assign cpu_req   = cpu_rd | cpu_wr;
  assign last_beat = &cnt_reg;

  // Outside IDLE the latched miss index drives the store, so a CPU that drops
  // or changes its request mid-burst cannot redirect the victim/install line.
  assign lookup_idx = (state_reg == ST_IDLE) ? cpu_idx : req_idx_reg;

  d_cache_tag_store #(
    .INDEX_W  (INDEX_W),
    .TAG_BITS (TW)
  ) u_tag_store (
    .clk         (clk),
    .RST         (RST),
    .idx         (lookup_idx),
    .lookup_tag  (cpu_tag),
    .hit         (tag_hit),
    .line_valid  (line_valid),
    .line_dirty  (line_dirty),
    .line_tag    (line_tag),
    .install     (install),
    .install_tag (req_tag_reg),
    .set_dirty   (hit_wr)
  );

  assign d_cache_miss = (state_reg != ST_IDLE) || (cpu_req && !tag_hit);
  assign hit_wr       = cpu_wr && tag_hit && !d_cache_miss;
  assign cpu_rdata    = data_mem[cpu_idx][cpu_off];

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      state_reg   <= ST_IDLE;
      cnt_reg     <= '0;
      req_tag_reg <= '0;
      req_idx_reg <= '0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      req_tag_reg <= req_tag_next;
      req_idx_reg <= req_idx_next;
    end
  end

  always_ff @(posedge clk) begin
    if (fill_wr) begin
      data_mem[req_idx_reg][cnt_reg] <= mem_rdata;
    end else if (hit_wr) begin
      data_mem[cpu_idx][cpu_off] <= cpu_wdata;
    end
  end

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    req_tag_next = req_tag_reg;
    req_idx_next = req_idx_reg;
    install      = 1'b0;
    fill_wr      = 1'b0;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    case (state_reg)
      ST_IDLE: begin
        cnt_next = '0;
        if (cpu_req && !tag_hit) begin
          req_tag_next = cpu_tag;
          req_idx_next = cpu_idx;
          state_next   = (line_valid && line_dirty) ? ST_WB : ST_FILL;
        end
      end
      ST_WB: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {line_tag, req_idx_reg, cnt_reg};
        mem_wdata = data_mem[req_idx_reg][cnt_reg];
        if (mem_ack) begin
          cnt_next = cnt_reg + 1'b1;
          if (last_beat) begin
            state_next = ST_FILL;
          end
        end
      end
      ST_FILL: begin
        mem_req  = 1'b1;
        mem_addr = {req_tag_reg, req_idx_reg, cnt_reg};
        if (mem_ack) begin
          fill_wr  = 1'b1;
          cnt_next = cnt_reg + 1'b1;
          if (last_beat) begin
            state_next = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        install    = 1'b1;
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_d_cache_ctrl.sv
// Self-checking bench: vector table of CPU accesses, a memory responder with
// wait states, and a queue of expected memory beats checked on every ack.
module tb_d_cache_ctrl;

  logic        clk;
  logic        RST;
  logic        cpu_rd;
  logic        cpu_wr;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic [7:0]  cpu_rdata;
  logic        d_cache_miss;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        mem_ack;

  d_cache_ctrl dut (
    .clk          (clk),
    .RST          (RST),
    .cpu_rd       (cpu_rd),
    .cpu_wr       (cpu_wr),
    .cpu_addr     (cpu_addr),
    .cpu_wdata    (cpu_wdata),
    .cpu_rdata    (cpu_rdata),
    .d_cache_miss (d_cache_miss),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .mem_ack      (mem_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [15:0] addr;
    logic [7:0]  wdata;
    int          waits;
    logic        wb;
    logic [15:0] wb_base;
    logic        fill;
    int          exp_miss;
    int          exp_req;
    logic [7:0]  exp_rdata;
  } vec_t;

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [7:0]  data;
  } beat_t;

  beat_t      expq[$];
  vec_t       vecs[10];
  logic [7:0] mem_model [65536];
  logic [7:0] cpu_view  [65536];
  int         n_vec = 0;
  int         n_bad = 0;
  int         waits = 0;
  int         acks_seen = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic preload(input logic [15:0] base, input logic [7:0] d0);
    for (int i = 0; i < 4; i++) begin
      mem_model[base + 16'(i)] = d0 + 8'(i);
      cpu_view[base + 16'(i)]  = d0 + 8'(i);
    end
  endtask

  // Memory model: waits idle cycles, then one ack per beat; each ack is
  // checked against the scoreboard before the DUT consumes it.
  initial begin
    int wait_cnt;
    beat_t b;
    wait_cnt  = 0;
    mem_ack   = 1'b0;
    mem_rdata = 8'h00;
    forever begin
      @(negedge clk);
      if (mem_req === 1'b1) begin
        if (wait_cnt < waits) begin
          wait_cnt++;
          mem_ack = 1'b0;
        end else begin
          wait_cnt = 0;
          mem_ack  = 1'b1;
          if (expq.size() == 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL unexpected_beat: got we=%0b addr=%h expected none", mem_we, mem_addr);
          end else begin
            b = expq.pop_front();
            chk("beat_we", 32'(mem_we), 32'(b.we));
            chk("beat_addr", 32'(mem_addr), 32'(b.addr));
            if (b.we) chk("beat_wdata", 32'(mem_wdata), 32'(b.data));
          end
          if (mem_we) mem_model[mem_addr] = mem_wdata;
          mem_rdata = mem_model[mem_addr];
          acks_seen++;
        end
      end else begin
        wait_cnt = 0;
        mem_ack  = 1'b0;
      end
    end
  end

  task automatic run_vec(input vec_t v, input int id);
    int    miss_n;
    int    req_n;
    logic  done;
    beat_t b;
    logic [15:0] line;
    waits = v.waits;
    line  = {v.addr[15:2], 2'b00};
    if (v.wb) begin
      for (int i = 0; i < 4; i++) begin
        b.we = 1'b1; b.addr = v.wb_base + 16'(i); b.data = cpu_view[v.wb_base + 16'(i)];
        expq.push_back(b);
      end
    end
    if (v.fill) begin
      for (int i = 0; i < 4; i++) begin
        b.we = 1'b0; b.addr = line + 16'(i); b.data = 8'h00;
        expq.push_back(b);
      end
    end
    cpu_rd = v.rd; cpu_wr = v.wr; cpu_addr = v.addr; cpu_wdata = v.wdata;
    miss_n = 0; req_n = 0; done = 1'b0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (d_cache_miss === 1'b0) begin
        done = 1'b1;
        break;
      end
      miss_n++;
      if (mem_req === 1'b1) req_n++;
    end
    chk("miss_ends", 32'(done), 32'd1);
    chk("miss_cycles", miss_n, v.exp_miss);
    chk("req_cycles", req_n, v.exp_req);
    chk("cpu_rdata", 32'(cpu_rdata), 32'(v.exp_rdata));
    chk("beats_left", expq.size(), 0);
    $display("vec %0d rd=%0b wr=%0b addr=%h miss=%0d req=%0d rdata=%h",
             id, v.rd, v.wr, v.addr, miss_n, req_n, cpu_rdata);
    @(posedge clk);
    #1;
    if (v.wr) cpu_view[v.addr] = v.wdata;
    cpu_rd = 1'b0;
    cpu_wr = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    int   a0;
    logic found;
    RST = 1'b1; cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_addr = 16'h0; cpu_wdata = 8'h0;
    preload(16'h1230, 8'hA0);
    preload(16'h5630, 8'hB0);
    preload(16'h7774, 8'hC4);
    preload(16'h0034, 8'hD0);
    preload(16'h2208, 8'hE0);

    //            rd    wr    addr      wdata  wt wb    wb_base   fill  miss req rdata
    vecs[0] = '{1'b1, 1'b0, 16'h1231, 8'h00, 0, 1'b0, 16'h0000, 1'b1,  6,  4, 8'hA1};
    vecs[1] = '{1'b0, 1'b1, 16'h1232, 8'h55, 0, 1'b0, 16'h0000, 1'b0,  0,  0, 8'hA2};
    vecs[2] = '{1'b1, 1'b0, 16'h1232, 8'h00, 0, 1'b0, 16'h0000, 1'b0,  0,  0, 8'h55};
    vecs[3] = '{1'b1, 1'b0, 16'h5632, 8'h00, 0, 1'b1, 16'h1230, 1'b1, 10,  8, 8'hB2};
    vecs[4] = '{1'b0, 1'b1, 16'h7774, 8'h3C, 2, 1'b0, 16'h0000, 1'b1, 14, 12, 8'hC4};
    vecs[5] = '{1'b1, 1'b0, 16'h7774, 8'h00, 0, 1'b0, 16'h0000, 1'b0,  0,  0, 8'h3C};
    vecs[6] = '{1'b1, 1'b0, 16'h0036, 8'h00, 0, 1'b1, 16'h7774, 1'b1, 10,  8, 8'hD2};
    vecs[7] = '{1'b1, 1'b1, 16'h5631, 8'h99, 0, 1'b0, 16'h0000, 1'b0,  0,  0, 8'hB1};
    vecs[8] = '{1'b1, 1'b0, 16'h5631, 8'h00, 0, 1'b0, 16'h0000, 1'b0,  0,  0, 8'h99};
    vecs[9] = '{1'b1, 1'b0, 16'h1232, 8'h00, 0, 1'b1, 16'h5630, 1'b1, 10,  8, 8'h55};

    repeat (2) @(negedge clk);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_miss", 32'(d_cache_miss), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    @(posedge clk);
    #1;
    RST = 1'b0;

    for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

    // Reset during the third fill beat of a one-wait-state burst.
    waits = 1;
    for (int i = 0; i < 4; i++) begin
      beat_t b;
      b.we = 1'b0; b.addr = 16'h2208 + 16'(i); b.data = 8'h00;
      expq.push_back(b);
    end
    a0 = acks_seen;
    cpu_rd = 1'b1; cpu_addr = 16'h2208;
    found = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(posedge clk);
      #2;
      if ((acks_seen - a0) >= 2 && mem_req === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
    chk("rst_third_beat", 32'(found), 32'd1);
    cpu_rd = 1'b0;
    RST = 1'b1;
    #1;
    chk("midrst_mem_req", 32'(mem_req), 32'd0);
    chk("midrst_mem_we", 32'(mem_we), 32'd0);
    chk("midrst_miss", 32'(d_cache_miss), 32'd0);
    chk("midrst_mem_addr", 32'(mem_addr), 32'd0);
    $display("reset mid-fill after %0d beats, mem_req=%0b", acks_seen - a0, mem_req);
    expq.delete();
    @(posedge clk);
    #1;
    RST = 1'b0;

    v = '{1'b1, 1'b0, 16'h2208, 8'h00, 0, 1'b0, 16'h0000, 1'b1, 6, 4, 8'hE0};
    run_vec(v, 10);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
